// File: rtl/shift_pkg.sv
// Shared definitions for the parametrised shift unit.
//   - mode encodings MODE_ROL..MODE_SRA (5..7 are reserved and do not shift)
//   - FSM state type for the shift sequencer
//   - cnt_w(): width of the step-count field for a given register width
package shift_pkg;

  localparam logic [2:0] MODE_ROL = 3'd0;
  localparam logic [2:0] MODE_ROR = 3'd1;
  localparam logic [2:0] MODE_SLL = 3'd2;
  localparam logic [2:0] MODE_SRL = 3'd3;
  localparam logic [2:0] MODE_SRA = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Step counter / amount width. WIDTH >= 2, so this is always at least 1.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit combinational shift of a WIDTH-bit word.
// Ports:
//   din     - current value
//   mode    - shift mode (shift_pkg MODE_*); reserved codes pass din through
//   dout    - value after one step
//   out_bit - bit leaving the word (the wrapped bit for rotates)
//   shifted - 1 when mode is a real shift, 0 for reserved codes
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic             out_bit,
  output logic             shifted
);

  always_comb begin
    dout    = din;
    out_bit = 1'b0;
    shifted = 1'b1;
    case (mode)
      MODE_ROL: begin
        dout    = {din[WIDTH-2:0], din[WIDTH-1]};
        out_bit = din[WIDTH-1];
      end
      MODE_ROR: begin
        dout    = {din[0], din[WIDTH-1:1]};
        out_bit = din[0];
      end
      MODE_SLL: begin
        dout    = {din[WIDTH-2:0], 1'b0};
        out_bit = din[WIDTH-1];
      end
      MODE_SRL: begin
        dout    = {1'b0, din[WIDTH-1:1]};
        out_bit = din[0];
      end
      MODE_SRA: begin
        dout    = {din[WIDTH-1], din[WIDTH-1:1]};
        out_bit = din[0];
      end
      default: shifted = 1'b0;
    endcase
  end

endmodule

// File: rtl/param_shift_unit.sv
// WIDTH-bit register with parallel load and a command-driven multi-cycle
// shift sequencer (one bit per cycle, busy/done handshake).
// Optional feature macro: SHIFT_CARRY_EN (adds the carry output).
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   load_en   - parallel load strobe (wins over everything but reset)
//   load_val  - value loaded on load_en
//   start     - command strobe, only honoured in IDLE
//   mode      - shift mode (shift_pkg MODE_*)
//   amount    - number of one-bit steps, 0..WIDTH-1
//   busy      - high while shifting
//   done      - one-cycle completion pulse
//   carry     - last bit shifted out (SHIFT_CARRY_EN only)
//   op        - register contents
module param_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FREE_RUN = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [WIDTH-1:0]          load_val,
  input  logic                      start,
  input  logic [2:0]                mode,
  input  logic [cnt_w(WIDTH)-1:0]   amount,
  output logic                      busy,
  output logic                      done,
`ifdef SHIFT_CARRY_EN
  output logic                      carry,
`endif
  output logic [WIDTH-1:0]          op
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       mode_q;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;
  logic             step_shifted;

  // The single stepper serves both the sequencer and the idle free-run
  // rotate; outside SHIFT it is forced to ROL.
  assign step_mode = (state == ST_SHIFT) ? mode_q : MODE_ROL;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .din     (op),
    .mode    (step_mode),
    .dout    (step_val),
    .out_bit (step_bit),
    .shifted (step_shifted)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!load_en && start)
          state_nxt = (amount == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (load_en)                 state_nxt = ST_IDLE;  // abort, no done
        else if (cnt == CW'(1))      state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op     <= '0;
      cnt    <= '0;
      mode_q <= MODE_ROL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_en) begin
            op <= load_val;
          end else if (start) begin
            mode_q <= mode;
            cnt    <= amount;
          end else if (FREE_RUN != 0) begin
            op <= step_val;
          end
        end
        ST_SHIFT: begin
          if (load_en) begin
            op  <= load_val;
            cnt <= '0;
          end else begin
            op  <= step_val;
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          if (load_en) op <= load_val;
        end
      endcase
    end
  end

`ifdef SHIFT_CARRY_EN
  // Only sequencer steps of a real shift mode touch carry; free-run rotation
  // and reserved modes leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   carry <= 1'b0;
    else if (load_en)                          carry <= 1'b0;
    else if (state == ST_SHIFT && step_shifted) carry <= step_bit;
  end
`else
  logic unused_step;
  assign unused_step = step_bit ^ step_shifted;
`endif

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_param_shift_unit.sv
module tb_param_shift_unit;
  import shift_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_en = 1'b0, start = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [2:0]   mode = '0;
  logic [2:0]   amount = '0;
  logic         busy, done;
  logic [W-1:0] op;
  logic         carry_o;

  logic         load_en1 = 1'b0, start1 = 1'b0;
  logic [W-1:0] load_val1 = '0;
  logic [2:0]   mode1 = '0;
  logic [2:0]   amount1 = '0;
  logic         busy1, done1;
  logic [W-1:0] op1;
  logic         carry1_o;

  always #5 clk = ~clk;

  param_shift_unit #(.WIDTH(W), .FREE_RUN(0)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_val(load_val),
    .start(start), .mode(mode), .amount(amount), .busy(busy), .done(done),
`ifdef SHIFT_CARRY_EN
    .carry(carry_o),
`endif
    .op(op)
  );

  param_shift_unit #(.WIDTH(W), .FREE_RUN(1)) dut_fr (
    .clk(clk), .rst(rst), .load_en(load_en1), .load_val(load_val1),
    .start(start1), .mode(mode1), .amount(amount1), .busy(busy1), .done(done1),
`ifdef SHIFT_CARRY_EN
    .carry(carry1_o),
`endif
    .op(op1)
  );

`ifndef SHIFT_CARRY_EN
  assign carry_o  = 1'b0;
  assign carry1_o = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] op;
    int           busy_cycles;
    logic         carry;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles of the current command and scores each done.
  int   busy_cnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
    end else if (done) begin
      if (prev_done) chk("done_single_cycle", 1, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_op", int'(op), int'(e.op));
        chk("sb_busy_cycles", busy_cnt, e.busy_cycles);
`ifdef SHIFT_CARRY_EN
        chk("sb_carry", int'(carry_o), int'(e.carry));
`endif
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
    prev_done = done;
  end

  task automatic do_load(input logic [W-1:0] v);
    @(posedge clk); #1;
    load_en = 1'b1; load_val = v;
    @(posedge clk); #1;
    load_en = 1'b0;
    chk("load_op", int'(op), int'(v));
  endtask

  task automatic do_cmd(input logic [2:0] m, input logic [2:0] n,
                        input logic [W-1:0] e_op, input logic e_carry);
    exp_t e;
    e.op = e_op; e.busy_cycles = int'(n); e.carry = e_carry;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; mode = m; amount = n;
    @(posedge clk); #1;
    start = 1'b0; mode = 3'd0; amount = 3'd0;
    repeat (int'(n) + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_op", int'(op), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_op_fr", int'(op1), 0);
`ifdef SHIFT_CARRY_EN
    chk("rst_carry", int'(carry_o), 0);
`endif
    rst = 1'b0;

    do_load(8'h81); do_cmd(MODE_ROL, 3'd1, 8'h03, 1'b1);
    do_load(8'h96); do_cmd(MODE_SRA, 3'd3, 8'hF2, 1'b1);
    do_load(8'h96); do_cmd(MODE_ROR, 3'd4, 8'h69, 1'b0);
    do_load(8'h80); do_cmd(MODE_SRL, 3'd7, 8'h01, 1'b0);
    do_load(8'h5A); do_cmd(MODE_ROL, 3'd0, 8'h5A, 1'b0);
    do_cmd(3'd6, 3'd2, 8'h5A, 1'b0);

    // Abort: SLL 5 on 0xFF, load 0x3C during the 2nd busy cycle
    do_load(8'hFF);
    @(posedge clk); #1;
    start = 1'b1; mode = MODE_SLL; amount = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy1", int'(busy), 1);
    @(posedge clk); #1;
    chk("abort_mid_op", int'(op), 8'hFE);
    load_en = 1'b1; load_val = 8'h3C;
    @(posedge clk); #1;
    load_en = 1'b0;
    chk("abort_op", int'(op), 8'h3C);
    chk("abort_busy", int'(busy), 0);
`ifdef SHIFT_CARRY_EN
    chk("abort_carry", int'(carry_o), 0);
`endif
    repeat (8) @(posedge clk);
    #1;

    // start held during busy with different mode/amount is ignored
    do_load(8'h01);
    sb.push_back('{op: 8'h08, busy_cycles: 3, carry: 1'b0});
    @(posedge clk); #1;
    start = 1'b1; mode = MODE_ROL; amount = 3'd3;
    @(posedge clk); #1;
    mode = MODE_SRL; amount = 3'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // load_en + start together in IDLE: load only
    @(posedge clk); #1;
    load_en = 1'b1; load_val = 8'h42; start = 1'b1; mode = MODE_ROL; amount = 3'd1;
    @(posedge clk); #1;
    load_en = 1'b0; start = 1'b0;
    chk("ld_start_op", int'(op), 8'h42);
    chk("ld_start_busy", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset mid-SHIFT
    do_load(8'hA5);
    @(posedge clk); #1;
    start = 1'b1; mode = MODE_ROL; amount = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_op", int'(op), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_load(8'h81); do_cmd(MODE_ROL, 3'd1, 8'h03, 1'b1);

    // FREE_RUN instance
    @(posedge clk); #1;
    load_en1 = 1'b1; load_val1 = 8'h01;
    @(posedge clk); #1;
    load_en1 = 1'b0;
    chk("fr_load", int'(op1), 8'h01);
    repeat (3) @(posedge clk);
    #1;
    chk("fr_idle3", int'(op1), 8'h08);
    start1 = 1'b1; mode1 = MODE_SRL; amount1 = 3'd2;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("fr_accept_op", int'(op1), 8'h08);
    chk("fr_accept_busy", int'(busy1), 1);
    @(posedge clk); #1;
    chk("fr_step1", int'(op1), 8'h04);
    @(posedge clk); #1;
    chk("fr_step2", int'(op1), 8'h02);
    chk("fr_done", int'(done1), 1);
    @(posedge clk); #1;
    chk("fr_done_hold", int'(op1), 8'h02);
    chk("fr_done_clr", int'(done1), 0);
    @(posedge clk); #1;
    chk("fr_resume_rot", int'(op1), 8'h04);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_shift_unit.md
Name: param_shift_unit

Overview:
- Parametrised successor to the 8-bit load/rotate register.
- WIDTH-bit register with parallel load and a command-driven multi-cycle shift sequencer.
- Modes: rotate/logical/arithmetic, left/right, N steps, one bit per cycle, with busy/done handshake.
- Used as the datapath shifter in the module 3 ALU/shift exercises; optional legacy free-running rotate when idle.

Parameters:
- WIDTH, 8, register width; must be >= 2.
- FREE_RUN, 0, when 1 the register rotates left one bit every idle cycle (legacy behaviour).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load_en  input  1  parallel load strobe, highest priority after reset
- load_val  input  WIDTH  value loaded when load_en=1
- start  input  1  command strobe, sampled only in IDLE
- mode  input  3  0=ROL 1=ROR 2=SLL 3=SRL 4=SRA 5..7=reserved (no-op shift, op unchanged)
- amount  input  $clog2(WIDTH)  step count, 0..WIDTH-1
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse when a command completes
- op  output  WIDTH  register contents

Behaviour:
- Reset (async, active-high, no clock needed): op=0, busy=0, done=0, state=IDLE, step counter=0, latched mode=0. Reset mid-operation aborts immediately.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load_en=1: op<=load_val, stay IDLE; any start in the same cycle is dropped.
  - Else start=1: latch mode and amount. amount=0 goes to DONE; otherwise goes to SHIFT with count=amount.
  - Else if FREE_RUN=1: op rotates left 1. Else op holds.
- SHIFT:
  - Each cycle op<=step(op, latched mode) and count decrements.
  - When count==1 the final step is applied and the FSM goes to DONE.
  - load_en=1 in SHIFT: op<=load_val, go to IDLE, no done pulse (abort).
  - start in SHIFT is ignored.
- DONE: done=1 for exactly this cycle, op holds, next state IDLE. load_en in DONE loads op; the done pulse is still emitted.
- busy = (state==SHIFT). done = (state==DONE). Both are registered-state decodes, glitch-free.
- Latency: start accepted at edge t with amount=N>0 gives busy for N cycles; op final after edge t+N; done high in cycle t+N+1. For amount=0, done is high the cycle after acceptance.
- Step semantics:
  - ROL/ROR: wrap the MSB/LSB around.
  - SLL/SRL: shift in 0.
  - SRA: replicate the MSB.
- amount and mode are not re-sampled during SHIFT; input changes mid-command have no effect.

Optional Feature:
- Macro SHIFT_CARRY_EN.
- Defined: adds output carry (1 bit). Each step captures the bit shifted out (the wrapped bit for rotates). Carry is cleared on reset and on load, and holds in IDLE/DONE. FREE_RUN idle rotation does not update carry.
- Undefined: carry port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - mode encoding constants (MODE_ROL..MODE_SRA)
  - FSM state typedef (IDLE/SHIFT/DONE)
  - helper function for counter width, $clog2(WIDTH)
- Sub-module shift_step: combinational one-bit shift of WIDTH bits by mode. Outputs the next value and the shifted-out bit. Instantiated once by the sequencer and reused by the FREE_RUN path with mode forced to ROL.

Test Plan (WIDTH=8):
- Load 0x81, start ROL amount=1 -> op=0x03 after 1 cycle; busy high for 1 cycle; done pulse the next cycle. With SHIFT_CARRY_EN, carry=1.
- Load 0x96, start SRA amount=3 -> op=0xF2, busy high for exactly 3 cycles, done a single cycle. Then ROR amount=4 on 0x96 -> 0x69. SRL amount=7 on 0x80 -> 0x01.
- Start amount=0 on 0x5A -> busy never high, done next cycle, op=0x5A. Reserved mode 6, amount=2 -> op unchanged, done after 2 busy cycles.
- Abort and priority checks:
  - Start SLL amount=5 on 0xFF, assert load_en with 0x3C at the 2nd busy cycle -> op=0x3C, busy drops, no done.
  - start during busy is ignored.
  - Simultaneous load_en+start in IDLE -> load only.
- Assert rst asynchronously between clock edges mid-SHIFT -> op=0x00, busy=0, done=0 before the next edge. Operation resumes normally after release.
- FREE_RUN=1 build: load 0x01, idle 3 cycles -> 0x08. Start SRL amount=2 then proceeds normally (no extra rotation while busy).
